mmcm_drp_reconfig: RTL and testbench

//  DRP master that reprograms an MMCME2_ADV at runtime. Replaces tied-off DRP/RST pins.

---
 rtl/mmcm_drp_pkg.sv | 36 +++
 rtl/mmcm_drp_table.sv | 28 ++
 rtl/mmcm_drp_reconfig.sv | 216 +++++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_drp_pkg.sv
// Shared types for the MMCM DRP reconfiguration master: DRP widths,
// table entry layout, controller state encoding and the RMW merge helper.
package mmcm_drp_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  // One reprogramming step: where to write, which bits to keep, what to put elsewhere.
  typedef struct packed {
    logic [DRP_AW-1:0] addr;
    logic [DRP_DW-1:0] mask;   // 1 = keep the bit read back from the MMCM
    logic [DRP_DW-1:0] data;   // replacement bits where mask = 0
  } drp_ent_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_ON,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_VF_REQ,
    S_VF_WAIT,
    S_NEXT,
    S_RST_OFF,
    S_LOCK_WAIT
  } state_t;

  // Merge a DRP readback with an entry: keep masked bits, replace the rest.
  function automatic logic [DRP_DW-1:0] rmw(input logic [DRP_DW-1:0] old_v,
                                            input logic [DRP_DW-1:0] keep_m,
                                            input logic [DRP_DW-1:0] new_v);
    return (old_v & keep_m) | (new_v & ~keep_m);
  endfunction

endpackage

// File: rtl/mmcm_drp_table.sv
// Register file of DRP reprogramming entries: one synchronous write port,
// one combinational read port. Contents are deliberately not reset.
module mmcm_drp_table
  import mmcm_drp_pkg::*;
#(
  parameter int  NENT = 16,
  localparam int IW   = (NENT > 1) ? $clog2(NENT) : 1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_widx,
  input  drp_ent_t      i_wdata,
  input  logic [IW-1:0] i_ridx,
  output drp_ent_t      o_rdata
);

  drp_ent_t mem_q [NENT];

  // Write port; indices beyond a non-power-of-two depth are dropped.
  always_ff @(posedge i_clk) begin
    if (i_we && (int'(i_widx) < NENT)) begin
      mem_q[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = (int'(i_ridx) < NENT) ? mem_q[i_ridx] : '0;

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// DRP master that reprograms an MMCME2_ADV at runtime: hold the MMCM in reset,
// read-modify-write each table entry over DRP, release reset, wait for LOCKED.
// Build macro MMCM_DRP_VERIFY_EN: read every written register back and abort
// with o_error if the readback differs from what was written.
module mmcm_drp_reconfig
  import mmcm_drp_pkg::*;
#(
  parameter int  NENT         = 16,
  parameter int  DRDY_TIMEOUT = 255,
  parameter int  LOCK_TIMEOUT = 65535,
  localparam int IW           = (NENT > 1) ? $clog2(NENT) : 1,
  localparam int CW           = $clog2(NENT) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tbl_we,
  input  logic [IW-1:0]     i_tbl_idx,
  input  logic [DRP_AW-1:0] i_tbl_addr,
  input  logic [DRP_DW-1:0] i_tbl_mask,
  input  logic [DRP_DW-1:0] i_tbl_data,
  input  logic [CW-1:0]     i_count,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [DRP_AW-1:0] o_daddr,
  output logic [DRP_DW-1:0] o_di,
  output logic              o_den,
  output logic              o_dwe,
  input  logic [DRP_DW-1:0] i_do,
  input  logic              i_drdy,
  output logic              o_mmcm_rst,
  input  logic              i_locked
);

  // One timer serves both the DRDY and the LOCKED waits, so size it for the longer one.
  localparam int            TMAX      = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int            TW        = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DRDY_LAST = TW'(DRDY_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(NENT);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [DRP_DW-1:0] new_q, new_d;
  logic              mmcm_rst_q, mmcm_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              locked_meta_q, locked_sync_q;
  logic              idle;
  drp_ent_t          wr_ent;
  drp_ent_t          ent;

  assign idle   = (state_q == S_IDLE);
  assign wr_ent = '{addr: i_tbl_addr, mask: i_tbl_mask, data: i_tbl_data};

  // Table writes are only accepted while idle, so the table is frozen during a sequence.
  mmcm_drp_table #(.NENT(NENT)) u_table (
    .i_clk   (i_clk),
    .i_we    (i_tbl_we & idle),
    .i_widx  (i_tbl_idx),
    .i_wdata (wr_ent),
    .i_ridx  (idx_q[IW-1:0]),
    .o_rdata (ent)
  );

  // LOCKED is asynchronous to DCLK; two flops before the FSM looks at it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      locked_meta_q <= 1'b0;
      locked_sync_q <= 1'b0;
    end else begin
      locked_meta_q <= i_locked;
      locked_sync_q <= locked_meta_q;
    end
  end

  // Controller state and datapath registers; the MMCM is held in reset while i_rst_n is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      new_q      <= '0;
      mmcm_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      new_q      <= new_d;
      mmcm_rst_q <= mmcm_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic: one DRP op outstanding at a time, timeouts abort to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    new_d   = new_q;
    done_d  = 1'b0;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cnt_d   = (i_count > CNT_MAX) ? CNT_MAX : i_count;
          idx_d   = '0;
          state_d = S_RST_ON;
        end
      end
      S_RST_ON: begin
        state_d = (cnt_q == '0) ? S_RST_OFF : S_RD_REQ;
      end
      S_RD_REQ: begin
        tmr_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_drdy) begin
          new_d   = rmw(i_do, ent.mask, ent.data);
          state_d = S_WR_REQ;
        end else if (tmr_q == DRDY_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_WR_REQ: begin
        tmr_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (i_drdy) begin
`ifdef MMCM_DRP_VERIFY_EN
          state_d = S_VF_REQ;
`else
          state_d = S_NEXT;
`endif
        end else if (tmr_q == DRDY_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`ifdef MMCM_DRP_VERIFY_EN
      S_VF_REQ: begin
        tmr_d   = '0;
        state_d = S_VF_WAIT;
      end
      S_VF_WAIT: begin
        if (i_drdy) begin
          if (i_do != new_q) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end else if (tmr_q == DRDY_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`endif
      S_NEXT: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == cnt_q) ? S_RST_OFF : S_RD_REQ;
      end
      S_RST_OFF: begin
        tmr_d   = '0;
        state_d = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (locked_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmr_q == LOCK_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // MMCM reset covers the whole DRP phase and is released on the way to RST_OFF.
    mmcm_rst_d = !(state_d inside {S_IDLE, S_RST_OFF, S_LOCK_WAIT});
  end

  // DRP strobes decode straight from the state register, so each REQ state is one DEN pulse.
  assign o_den      = state_q inside {S_RD_REQ, S_WR_REQ, S_VF_REQ};
  assign o_dwe      = (state_q == S_WR_REQ);
  assign o_daddr    = o_den ? ent.addr : '0;
  assign o_di       = o_dwe ? new_q : '0;
  assign o_busy     = !idle;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_mmcm_rst = mmcm_rst_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Scoreboard bench for mmcm_drp_reconfig: a 128x16 DRP responder (DRDY latency 3)
// and a simple LOCKED model drive the DUT; stimulus pushes expected DRP ops and
// completion events, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mmcm_drp_reconfig;

  localparam int NENT = 16;
  localparam int DT   = 255;
  localparam int LT   = 100;
  localparam int IW   = 4;
  localparam int CW   = 5;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_tbl_we = 1'b0;
  logic [IW-1:0] i_tbl_idx = '0;
  logic [6:0]    i_tbl_addr = '0;
  logic [15:0]   i_tbl_mask = '0;
  logic [15:0]   i_tbl_data = '0;
  logic [CW-1:0] i_count = '0;
  logic          i_start = 1'b0;
  logic          o_busy, o_done, o_error, o_den, o_dwe, o_mmcm_rst;
  logic [6:0]    o_daddr;
  logic [15:0]   o_di;
  logic [15:0]   i_do = '0;
  logic          i_drdy = 1'b0;
  logic          i_locked = 1'b0;

  mmcm_drp_reconfig #(.NENT(NENT), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tbl_we(i_tbl_we), .i_tbl_idx(i_tbl_idx),
    .i_tbl_addr(i_tbl_addr), .i_tbl_mask(i_tbl_mask), .i_tbl_data(i_tbl_data),
    .i_count(i_count), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_daddr(o_daddr), .o_di(o_di), .o_den(o_den), .o_dwe(o_dwe),
    .i_do(i_do), .i_drdy(i_drdy), .o_mmcm_rst(o_mmcm_rst), .i_locked(i_locked)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic we; logic [6:0] addr; logic [15:0] di; } op_t;
  // kind: 0 no timing check, 1 lock rise + 3, 2 reset release + LT + 1, 3 last DEN + DT + 1
  typedef struct { logic is_err; int kind; } end_t;

  op_t  op_q[$];
  end_t end_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [15:0] regs [128];
  int          lat = 0;
  logic        p_we = 1'b0;
  logic [6:0]  p_a = '0;
  logic [15:0] p_di = '0;
  logic        den_prev = 1'b0;
  bit          drdy_dis = 1'b0;
  bit          corrupt = 1'b0;
  bit          lock_en = 1'b1;
  int          lk_cnt = 0;
  int          lock_rise_cyc = -1000;
  int          rst_fall_cyc = -1000;
  int          den_cyc = -1000;
  logic        rst_prev = 1'b1;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // DRP responder: latency 3, flags a DEN issued while an op is still outstanding.
  initial begin
    int lat0;
    forever begin
      @(posedge i_clk); #1;
      lat0 = lat;
      i_drdy = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          i_drdy = 1'b1;
          if (p_we) regs[p_a] = p_di ^ {15'b0, corrupt};
          else      i_do = regs[p_a];
        end
      end
      if (o_den && i_rst_n) begin
        chk("den_single_no_overlap", {30'b0, den_prev, (lat0 != 0)}, 32'd0);
        if (!drdy_dis) begin
          lat  = 3;
          p_we = o_dwe;
          p_a  = o_daddr;
          p_di = o_di;
        end
      end
      den_prev = o_den;
    end
  end

  // LOCKED model: low while in reset, rises 5 cycles after reset release when enabled.
  initial forever begin
    @(posedge i_clk); #1;
    if (o_mmcm_rst) begin
      i_locked = 1'b0;
      lk_cnt   = 0;
    end else if (lock_en && !i_locked) begin
      lk_cnt++;
      if (lk_cnt == 5) begin
        i_locked      = 1'b1;
        lock_rise_cyc = cyc;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a DRP op or finishes.
  initial begin
    op_t  e;
    end_t f;
    int   ecyc;
    forever begin
      @(negedge i_clk);
      if (rst_prev && !o_mmcm_rst) rst_fall_cyc = cyc;
      rst_prev = o_mmcm_rst;
      if (o_den) begin
        den_cyc = cyc;
        $display("op   cyc=%0d we=%0b addr=%h di=%h", cyc, o_dwe, o_daddr, o_di);
        if (op_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_op: got we=%0b addr=%h expected none", o_dwe, o_daddr);
        end else begin
          e = op_q.pop_front();
          chk("op_we", {31'b0, o_dwe}, {31'b0, e.we});
          chk("op_addr", {25'b0, o_daddr}, {25'b0, e.addr});
          if (e.we) chk("op_di", {16'b0, o_di}, {16'b0, e.di});
          chk("op_rst_held", {31'b0, o_mmcm_rst}, 32'd1);
        end
      end
      if (o_done || o_error) begin
        $display("end  cyc=%0d done=%0b error=%0b busy=%0b", cyc, o_done, o_error, o_busy);
        if (end_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_end: got done=%0b error=%0b expected none", o_done, o_error);
        end else begin
          f = end_q.pop_front();
          chk("end_kind", {30'b0, o_done, o_error}, {30'b0, !f.is_err, f.is_err});
          chk("end_busy_low", {31'b0, o_busy}, 32'd0);
          chk("end_rst_low", {31'b0, o_mmcm_rst}, 32'd0);
          if (f.kind != 0) begin
            ecyc = (f.kind == 1) ? lock_rise_cyc + 3 :
                   (f.kind == 2) ? rst_fall_cyc + LT + 1 : den_cyc + DT + 1;
            chk("end_cycle", cyc, ecyc);
          end
        end
      end
    end
  end

  task automatic push_op(input logic we, input logic [6:0] a, input logic [15:0] d);
    op_t e;
    e.we = we; e.addr = a; e.di = d;
    op_q.push_back(e);
  endtask

  task automatic push_rmw(input logic [6:0] a, input logic [15:0] nv);
    push_op(1'b0, a, 16'h0);
    push_op(1'b1, a, nv);
`ifdef MMCM_DRP_VERIFY_EN
    push_op(1'b0, a, 16'h0);
`endif
  endtask

  task automatic push_end(input logic is_err, input int kind);
    end_t f;
    f.is_err = is_err; f.kind = kind;
    end_q.push_back(f);
  endtask

  task automatic tbl_wr(input int idx, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    @(posedge i_clk); #1;
    i_tbl_we = 1'b1; i_tbl_idx = IW'(idx); i_tbl_addr = a; i_tbl_mask = m; i_tbl_data = d;
    @(posedge i_clk); #1;
    i_tbl_we = 1'b0;
  endtask

  task automatic do_start(input int cnt);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_count = CW'(cnt);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge i_clk);
      if (!o_busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: busy still %0b after 3000 cycles, expected 0", nm, o_busy);
    end
    repeat (12) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 128; i++) regs[i] = 16'h0;

    // Reset values
    repeat (3) @(posedge i_clk); #1;
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_done_err", {30'b0, o_done, o_error}, 32'd0);
    chk("rst_den_dwe", {30'b0, o_den, o_dwe}, 32'd0);
    chk("rst_daddr_di", {9'b0, o_daddr, o_di}, 32'd0);
    chk("rst_mmcm_rst", {31'b0, o_mmcm_rst}, 32'd1);
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk); #1;
    chk("idle_mmcm_rst", {31'b0, o_mmcm_rst}, 32'd0);
    repeat (10) @(posedge i_clk); #1;

    // Single entry RMW: 0x1041 keep top nibble, new 0x082 -> 0x1082
    regs[7'h08] = 16'h1041;
    tbl_wr(0, 7'h08, 16'hF000, 16'h0082);
    push_rmw(7'h08, 16'h1082);
    push_end(1'b0, 1);
    do_start(1);
    wait_idle("t1");
    chk("t1_reg08", {16'b0, regs[7'h08]}, 32'h1082);

    // Three entries in order; start and table write while busy must be ignored
    regs[7'h09] = 16'h1234;
    regs[7'h14] = 16'h5555;
    tbl_wr(1, 7'h09, 16'h00FF, 16'hAB00);
    tbl_wr(2, 7'h14, 16'h0000, 16'hBEEF);
    push_rmw(7'h08, 16'h1082);
    push_rmw(7'h09, 16'hAB34);
    push_rmw(7'h14, 16'hBEEF);
    push_end(1'b0, 1);
    do_start(3);
    repeat (3) @(posedge i_clk); #1;
    i_start = 1'b1; i_count = CW'(1);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_tbl_we = 1'b1; i_tbl_idx = IW'(1); i_tbl_addr = 7'h09; i_tbl_mask = 16'h0; i_tbl_data = 16'hDEAD;
    @(posedge i_clk); #1;
    i_tbl_we = 1'b0;
    wait_idle("t2");
    chk("t2_reg09", {16'b0, regs[7'h09]}, 32'hAB34);
    chk("t2_reg14", {16'b0, regs[7'h14]}, 32'hBEEF);

    // Rerun: entry 1 must still be the original {0x09, 0x00FF, 0xAB00}
    regs[7'h09] = 16'h0000;
    push_rmw(7'h08, 16'h1082);
    push_rmw(7'h09, 16'hAB00);
    push_rmw(7'h14, 16'hBEEF);
    push_end(1'b0, 1);
    do_start(3);
    wait_idle("t3");
    chk("t3_reg09", {16'b0, regs[7'h09]}, 32'hAB00);

    // Table write and start in the same idle cycle: sequence uses the new entry
    regs[7'h20] = 16'h0F0F;
    push_rmw(7'h20, 16'h770F);
    push_end(1'b0, 1);
    @(posedge i_clk); #1;
    i_tbl_we = 1'b1; i_tbl_idx = IW'(0); i_tbl_addr = 7'h20; i_tbl_mask = 16'h00FF; i_tbl_data = 16'h7700;
    i_start = 1'b1; i_count = CW'(1);
    @(posedge i_clk); #1;
    i_tbl_we = 1'b0; i_start = 1'b0;
    wait_idle("t4");
    chk("t4_reg20", {16'b0, regs[7'h20]}, 32'h770F);

    // DRDY never returns: error DT+1 cycles after the read DEN, no write issued
    drdy_dis = 1'b1;
    push_op(1'b0, 7'h20, 16'h0);
    push_end(1'b1, 3);
    do_start(1);
    wait_idle("t5");
    drdy_dis = 1'b0;

    // LOCKED stays low: error LT+1 cycles after reset release
    lock_en = 1'b0;
    push_rmw(7'h20, 16'h770F);
    push_end(1'b1, 2);
    do_start(1);
    wait_idle("t6");
    lock_en = 1'b1;
    repeat (10) @(posedge i_clk); #1;

`ifdef MMCM_DRP_VERIFY_EN
    // Responder flips bit 0 on write: readback mismatch aborts with error
    corrupt = 1'b1;
    regs[7'h20] = 16'h1234;
    push_rmw(7'h20, 16'h7734);
    push_end(1'b1, 0);
    do_start(1);
    wait_idle("t7");
    corrupt = 1'b0;
    chk("t7_reg20", {16'b0, regs[7'h20]}, 32'h7735);
`endif

    // Reset pulse while waiting for read DRDY
    push_op(1'b0, 7'h20, 16'h0);
    do_start(1);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      if (o_den) begin seen = 1'b1; break; end
    end
    chk("t8_den_seen", {31'b0, seen}, 32'd1);
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("t8_busy", {31'b0, o_busy}, 32'd0);
    chk("t8_den_dwe", {30'b0, o_den, o_dwe}, 32'd0);
    chk("t8_daddr_di", {9'b0, o_daddr, o_di}, 32'd0);
    chk("t8_done_err", {30'b0, o_done, o_error}, 32'd0);
    chk("t8_mmcm_rst", {31'b0, o_mmcm_rst}, 32'd1);
    repeat (3) @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (10) @(posedge i_clk); #1;
    chk("t8_idle_after", {30'b0, o_busy, o_mmcm_rst}, 32'd0);

    repeat (10) @(posedge i_clk); #1;
    chk("ops_left", op_q.size(), 32'd0);
    chk("ends_left", end_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
